fsqrt_ieee_seq: RTL
===================

Name: fsqrt_ieee_seq

Overview:
- Single-precision IEEE-754 square-root sequencer wrapped around the Newton-Raphson root unit.
- Upstream side: accepts an operand via a valid/ready handshake, unpacks and normalizes it, and builds the 24-bit radicand d. It also handles denormals, computes the result exponent, and issues the fsqrt start pulse.
- Downstream side: waits out the iterations and the 3-stage root output pipeline, then samples q.
- Rounds, packs and handles special operands, and presents the result on a valid/ready handshake.

Parameters:
- DRAIN_CYCLES, 3: cycles from first root_busy==0 sample until q holds the final root (id-e1, e1-e2, e2-e3).
- EXPW, 10: signed internal exponent width.

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- in_valid  in  1  operand offered
- in_ready  out  1  block idle, operand accepted when in_valid&in_ready
- a  in  32  IEEE-754 single operand
- rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
- root_d  out  24  radicand to root unit (.1xx..x or .01x..x)
- root_fsqrt  out  1  one-cycle start pulse to root unit
- root_busy  in  1  root unit busy
- root_q  in  32  root .1xxx..x, bit0 sticky
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  32  IEEE-754 result
- flag_invalid  out  1  invalid operation
- flag_inexact  out  1  result rounded

Behaviour:
- Reset values: all outputs 0 except in_ready=1; FSM=IDLE. Reset mid-operation aborts and drops the operation. The root unit shares clrn. The root pipeline enable is tied high.
- FSM states: IDLE, ISSUE, ITER, DRAIN, PACK, RESULT.
- IDLE: in_ready=1. On in_valid, latch a and rm, compute root_d and exponent, go to ISSUE.
- ISSUE: root_fsqrt=1 for exactly this one cycle, then go to ITER.
- ITER: wait for root_busy==0; that cycle is drain cycle 1, go to DRAIN.
- DRAIN: count to DRAIN_CYCLES total, then go to PACK.
- PACK: sample root_q, round, pack, and register outputs, then go to RESULT.
- RESULT: out_valid=1 with result and flags held stable until out_ready; on handshake go to IDLE.
- in_ready is 0 in every state except IDLE. root_d is held constant from ISSUE through PACK.
- Latency: out_valid rises 27 cycles after the accept edge. Throughput is one operation per 27 cycles plus the handshake.
- Unpack:
  - Normal operand: ee = biased e.
  - Denormal (e=0, f!=0): shift {0,f} left by lz until the hidden bit is set; ee = 1-lz.
- Radicand and exponent:
  - ee even: root_d = {1,f[22:0]}; exp = ee/2 + 63.
  - ee odd: root_d = {0,1,f[22:1]}; exp = (ee-1)/2 + 64.
  - Both use signed EXPW arithmetic.
- Rounding:
  - Mantissa = root_q[30:8]; guard = root_q[7]; sticky = |root_q[6:0].
  - RNE: round up on guard & (sticky | lsb).
  - RTZ and RDN: truncate.
  - RUP: round up on guard | sticky.
  - flag_inexact = guard | sticky.
  - Mantissa carry-out: mantissa becomes 0 and exp increments.
- Specials (override at PACK; flag_inexact=0):
  - +/-0 returns the same zero.
  - +inf returns +inf.
  - NaN returns the input with bit22 forced to 1; flag_invalid=1 only if the input is an sNaN.
  - Negative nonzero (including -inf) returns 0x7FC00000 with flag_invalid=1.
- in_valid during non-IDLE states is ignored. out_ready while out_valid=0 is ignored.

Optional Feature:
FSQRT_SPECIAL_BYPASS_EN:
- Defined: special operands skip the root unit. No root_fsqrt pulse is issued. IDLE goes to RESULT directly with the special result registered, so out_valid rises 1 cycle after accept.
- Undefined: specials run the full sequence with the 27-cycle latency and are overridden at PACK.

Test Plan:
- a=0x40800000 (4.0), rm=00 -> result 0x40000000, inexact 0, out_valid exactly 27 cycles after accept, root_fsqrt high exactly one cycle.
- a=0x40000000 (2.0): rm=00 -> 0x3FB504F3; rm=01 -> 0x3FB504F3; rm=10 -> 0x3FB504F4. inexact 1 for all three.
- a=0x00000001 (min denormal), rm=00 -> 0x1A3504F3, root_d=0x800000.
- a=0xBF800000 (-1.0) -> 0x7FC00000, invalid 1. a=0x80000000 -> 0x80000000, flags 0. Latency is 27 or 1 per FSQRT_SPECIAL_BYPASS_EN.
- out_ready held 0 for 5 cycles in RESULT -> result and out_valid stable, in_ready 0, second in_valid not accepted until the handshake.
- clrn pulsed low during ITER -> out_valid 0, in_ready 1. A new a=0x3F800000 issued afterwards -> 0x3F800000.

Source files
------------

// File: rtl/fsqrt_ieee_seq.sv
// fsqrt_ieee_seq: single-precision IEEE-754 square-root sequencer.
// Front end unpacks/normalizes the operand and builds the radicand for an
// external Newton-Raphson root unit. Back end rounds, packs and handles
// special operands. A valid/ready handshake is used on both sides.
// Optional build macro: FSQRT_SPECIAL_BYPASS_EN -- special operands skip the
// root unit and are returned straight from IDLE.
module fsqrt_ieee_seq #(
  parameter int DRAIN_CYCLES = 3,
  parameter int EXPW         = 10
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [1:0]  rm,
  output logic [23:0] root_d,
  output logic        root_fsqrt,
  input  logic        root_busy,
  input  logic [31:0] root_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_invalid,
  output logic        flag_inexact
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic signed [EXPW-1:0] EXP_ONE  = EXPW'(32'sd1);
  localparam logic signed [EXPW-1:0] OFS_EVEN = EXPW'(32'sd63);
  localparam logic signed [EXPW-1:0] OFS_ODD  = EXPW'(32'sd64);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    ITER   = 3'd2,
    DRAIN  = 3'd3,
    PACK   = 3'd4,
    RESULT = 3'd5
  } state_t;

  typedef struct packed {
    logic        hit;
    logic        inv;
    logic [31:0] res;
  } special_t;

  // Leading-zero count of a 24-bit vector (24 when all zero).
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       seen;
    n    = 5'd0;
    seen = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (seen || v[i]) begin
        seen = 1'b1;
      end else begin
        n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Classify zero / NaN / negative / +inf operands and give their result.
  function automatic special_t classify(input logic [31:0] x);
    special_t s;
    s.hit = 1'b1;
    s.inv = 1'b0;
    s.res = x;
    if ((x[30:23] == 8'd0) && (x[22:0] == 23'd0)) begin
      s.res = x;
    end else if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) begin
      s.res = x | 32'h0040_0000;
      s.inv = ~x[22];
    end else if (x[31]) begin
      s.res = 32'h7FC0_0000;
      s.inv = 1'b1;
    end else if (x[30:23] == 8'hFF) begin
      s.res = x;
    end else begin
      s.hit = 1'b0;
    end
    return s;
  endfunction

  state_t                 state_r;
  logic [CW-1:0]          cnt_r;
  logic [31:0]            a_r;
  logic [1:0]             rm_r;
  logic signed [EXPW-1:0] exp_r;

  logic [7:0]             e_s;
  logic [22:0]            f_s;
  logic [4:0]             lz_s;
  logic [23:0]            m_s;
  logic signed [EXPW-1:0] ee_s;
  logic [23:0]            d_s;
  logic signed [EXPW-1:0] exp_s;

  logic [22:0]            mant_s;
  logic                   guard_s;
  logic                   sticky_s;
  logic                   up_s;
  logic [23:0]            sum_s;
  logic [22:0]            mant_out_s;
  logic signed [EXPW-1:0] exp_out_s;
  logic [31:0]            packed_s;
  special_t               spec_s;
  logic                   unused_s;

  // Unpack the incoming operand, normalize denormals, build radicand and exponent.
  always_comb begin
    e_s  = a[30:23];
    f_s  = a[22:0];
    lz_s = lzc24({1'b0, f_s});
    m_s  = {1'b0, f_s} << lz_s;
    if (e_s == 8'd0) begin
      ee_s = EXP_ONE - $signed({{(EXPW-5){1'b0}}, lz_s});
    end else begin
      ee_s = $signed({{(EXPW-8){1'b0}}, e_s});
      m_s  = {1'b1, f_s};
    end
    if (ee_s[0]) begin
      d_s   = {2'b01, m_s[22:1]};
      exp_s = (ee_s >>> 1) + OFS_ODD;
    end else begin
      d_s   = {1'b1, m_s[22:0]};
      exp_s = (ee_s >>> 1) + OFS_EVEN;
    end
  end

  // Round the sampled root per the latched mode and pack the result word.
  always_comb begin
    mant_s   = root_q[30:8];
    guard_s  = root_q[7];
    sticky_s = |root_q[6:0];
    case (rm_r)
      2'b00:   up_s = guard_s & (sticky_s | mant_s[0]);
      2'b01:   up_s = 1'b0;
      2'b10:   up_s = guard_s | sticky_s;
      2'b11:   up_s = 1'b0;
      default: up_s = 1'b0;
    endcase
    sum_s = {1'b0, mant_s} + {23'd0, up_s};
    if (sum_s[23]) begin
      mant_out_s = 23'd0;
      exp_out_s  = exp_r + EXP_ONE;
    end else begin
      mant_out_s = sum_s[22:0];
      exp_out_s  = exp_r;
    end
    packed_s = {1'b0, exp_out_s[7:0], mant_out_s};
    spec_s   = classify(a_r);
  end

  // Bits that are architecturally unused (root integer bit, exponent headroom).
  assign unused_s = ^{root_q[31], m_s[23], exp_out_s[EXPW-1:8]};

`ifdef FSQRT_SPECIAL_BYPASS_EN
  special_t spec_in_s;

  // Special-operand detection on the live operand for the bypass path.
  always_comb begin
    spec_in_s = classify(a);
  end
`endif

  // Sequencer FSM with registered handshake, root-unit and result outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      a_r          <= 32'd0;
      rm_r         <= 2'd0;
      exp_r        <= '0;
      in_ready     <= 1'b1;
      root_d       <= 24'd0;
      root_fsqrt   <= 1'b0;
      out_valid    <= 1'b0;
      result       <= 32'd0;
      flag_invalid <= 1'b0;
      flag_inexact <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            rm_r     <= rm;
            root_d   <= d_s;
            exp_r    <= exp_s;
            in_ready <= 1'b0;
`ifdef FSQRT_SPECIAL_BYPASS_EN
            if (spec_in_s.hit) begin
              result       <= spec_in_s.res;
              flag_invalid <= spec_in_s.inv;
              flag_inexact <= 1'b0;
              out_valid    <= 1'b1;
              state_r      <= RESULT;
            end else begin
              root_fsqrt <= 1'b1;
              state_r    <= ISSUE;
            end
`else
            root_fsqrt <= 1'b1;
            state_r    <= ISSUE;
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end
        ISSUE: begin
          root_fsqrt <= 1'b0;
          state_r    <= ITER;
        end
        ITER: begin
          if (!root_busy) begin
            cnt_r   <= CNT_ONE;
            state_r <= DRAIN;
          end else begin
            cnt_r <= '0;
          end
        end
        DRAIN: begin
          if (cnt_r >= CNT_LAST) begin
            state_r <= PACK;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        PACK: begin
          if (spec_s.hit) begin
            result       <= spec_s.res;
            flag_invalid <= spec_s.inv;
            flag_inexact <= 1'b0;
          end else begin
            result       <= packed_s;
            flag_invalid <= 1'b0;
            flag_inexact <= guard_s | sticky_s;
          end
          out_valid <= 1'b1;
          state_r   <= RESULT;
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          in_ready   <= 1'b1;
          root_fsqrt <= 1'b0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
